// File: rtl/eval_result_tx.sv
// Return path to the Raspberry Pi: captures one batch of signed board scores, frames them
// as HEADER, 4*NUM_BOARDS score bytes (MSB first) and an XOR checksum, and sends each byte
// over a 4-phase valid/ack handshake.
module eval_result_tx #(
    parameter int         NUM_BOARDS = 7,
    parameter int         EVAL_WIDTH = 32,
    parameter logic [7:0] HEADER     = 8'hA5
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             batch_start,
    input  logic [NUM_BOARDS-1:0]            evaluation_stable,
    input  logic [NUM_BOARDS*EVAL_WIDTH-1:0] evaluations,
    input  logic                             rpi_ack,
    output logic [7:0]                       tx_data,
    output logic                             tx_valid,
    output logic                             tx_busy,
    output logic                             frame_done
);

    localparam int                NBYTES = 4 * NUM_BOARDS + 2;
    localparam int                CNT_W  = $clog2(NBYTES);
    localparam logic [CNT_W-1:0]  LAST_K = CNT_W'(NBYTES - 1);

    typedef enum logic [1:0] {COLLECT, LOAD, STROBE, WAIT_LO} state_t;

    state_t                        state_q;
    logic                          ack_meta_q, ack_s_q;
    logic [NUM_BOARDS-1:0]         flag_q;
    logic signed [EVAL_WIDTH-1:0]  score_q [NUM_BOARDS];
    logic [CNT_W-1:0]              k_q;
    logic [7:0]                    csum_q;
    logic [7:0]                    tx_data_q;
    logic                          tx_valid_q, tx_busy_q, frame_done_q;
    logic [7:0]                    byte_d;

    // rpi_ack comes straight off a GPIO pin, so only the synchronised copy is ever used.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
        end else begin
            ack_meta_q <= rpi_ack;
            ack_s_q    <= ack_meta_q;
        end
    end

    // Byte k_q+1 of the frame: score byte index k_q, or the checksum once k_q runs past the scores.
    always_comb begin
        byte_d = csum_q;
        for (int b = 0; b < NUM_BOARDS; b++) begin
            if (int'(k_q >> 2) == b) begin
                byte_d = score_q[b][{~k_q[1:0], 3'b000} +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= COLLECT;
            flag_q       <= '0;
            k_q          <= '0;
            csum_q       <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            tx_busy_q    <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < NUM_BOARDS; i++) begin
                score_q[i] <= '0;
            end
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                COLLECT: begin
                    // tx_busy still high here means this is the frame_done cycle: inputs ignored.
                    if (tx_busy_q) begin
                        tx_busy_q <= 1'b0;
                    end else if (batch_start) begin
                        flag_q <= '0;
                    end else begin
                        for (int i = 0; i < NUM_BOARDS; i++) begin
                            if (evaluation_stable[i] && !flag_q[i]) begin
                                score_q[i] <= $signed(evaluations[EVAL_WIDTH*i +: EVAL_WIDTH]);
                                flag_q[i]  <= 1'b1;
                            end
                        end
                        if (&flag_q && enable) begin
                            state_q   <= LOAD;
                            tx_data_q <= HEADER;
                            tx_busy_q <= 1'b1;
                            k_q       <= '0;
                            csum_q    <= '0;
                        end
                    end
                end
                LOAD: begin
                    if (!ack_s_q) begin
                        tx_valid_q <= 1'b1;
                        state_q    <= STROBE;
                        if (k_q != LAST_K) begin
                            csum_q <= csum_q ^ tx_data_q;
                        end
                    end
                end
                STROBE: begin
                    if (ack_s_q) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (!ack_s_q) begin
                        if (k_q == LAST_K) begin
                            frame_done_q <= 1'b1;
                            flag_q       <= '0;
                            k_q          <= '0;
                            csum_q       <= '0;
                            tx_data_q    <= '0;
                            state_q      <= COLLECT;
                        end else begin
                            k_q       <= k_q + 1'b1;
                            tx_data_q <= byte_d;
                            state_q   <= LOAD;
                        end
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign tx_busy    = tx_busy_q;
    assign frame_done = frame_done_q;

endmodule
